// File: rtl/seg_cmd_pkg.sv
// seg_cmd_pkg: shared state encoding, protocol bytes and command decode for seg_cmd_ctrl.
// Build option SEG_CMD_CKSUM_EN adds the CKSUM state for the 4-byte frame.
package seg_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
`ifdef SEG_CMD_CKSUM_EN
    ST_CKSUM,
`endif
    ST_EXEC,
    ST_RESP
  } state_t;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam logic [7:0] ACK           = 8'h06;
  localparam logic [7:0] NAK           = 8'h15;

  localparam logic [7:0] CMD_SET_DIGIT = 8'h01;
  localparam logic [7:0] CMD_CLEAR     = 8'h02;
  localparam logic [7:0] CMD_SET_BLANK = 8'h03;

  // True when the command code is known and its payload is legal for it.
  function automatic logic cmd_accepted(input logic [7:0] cmd, input logic [7:0] payload);
    case (cmd)
      CMD_SET_DIGIT: return (payload[7:6] == 2'b00);
      CMD_CLEAR:     return 1'b1;
      CMD_SET_BLANK: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_cmd_timeout.sv
// seg_cmd_timeout: inter-byte watchdog. Reloads to TIMEOUT_TICKS-1 on clear, counts
// down while enabled, and flags expire during the cycle it sits at zero with no clear.
module seg_cmd_timeout #(
  parameter int TIMEOUT_TICKS = 52080
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            CW       = $clog2(TIMEOUT_TICKS);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] count;

  // Reload on every clear, otherwise count down toward zero while a frame is open.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expire = enable && !clear && (count == '0);

endmodule

// File: rtl/seg_cmd_ctrl.sv
// seg_cmd_ctrl: parses framed UART commands, owns the seven-segment display registers
// and returns a one-byte ACK/NAK through a valid/ready handshake.
// Build option SEG_CMD_CKSUM_EN: frame is SYNC, CMD, PAYLOAD, CKSUM (CMD ^ PAYLOAD);
// when undefined the frame is SYNC, CMD, PAYLOAD and no checksum is checked.
module seg_cmd_ctrl
  import seg_cmd_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 52080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        rx_drop
);

  state_t     state, next_state;
  logic [7:0] cmd_q, payload_q;
`ifdef SEG_CMD_CKSUM_EN
  logic [7:0] cksum_q;
`endif
  logic       in_frame;
  logic       tmr_clear;
  logic       tmr_expire;
  logic       frame_good;
  logic       in_exec;

  // The watchdog restarts on every accepted byte and stays loaded outside a frame.
  assign tmr_clear = !in_frame || rx_valid;

  seg_cmd_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (in_frame),
    .expire (tmr_expire)
  );

`ifdef SEG_CMD_CKSUM_EN
  assign frame_good = cmd_accepted(cmd_q, payload_q) && (cksum_q == (cmd_q ^ payload_q));
`else
  assign frame_good = cmd_accepted(cmd_q, payload_q);
`endif

  assign in_exec = (state == ST_EXEC);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; an arriving byte always wins over a same-cycle timeout.
  always_comb begin
    next_state = state;
    in_frame   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) next_state = ST_CMD;
      end
      ST_CMD: begin
        in_frame = 1'b1;
        if (rx_valid)        next_state = ST_PAYLOAD;
        else if (tmr_expire) next_state = ST_IDLE;
      end
      ST_PAYLOAD: begin
        in_frame = 1'b1;
`ifdef SEG_CMD_CKSUM_EN
        if (rx_valid)        next_state = ST_CKSUM;
`else
        if (rx_valid)        next_state = ST_EXEC;
`endif
        else if (tmr_expire) next_state = ST_IDLE;
      end
`ifdef SEG_CMD_CKSUM_EN
      ST_CKSUM: begin
        in_frame = 1'b1;
        if (rx_valid)        next_state = ST_EXEC;
        else if (tmr_expire) next_state = ST_IDLE;
      end
`endif
      ST_EXEC: begin
        next_state = ST_RESP;
      end
      ST_RESP: begin
        if (tx_valid && tx_ready) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the frame fields as their bytes arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q     <= '0;
      payload_q <= '0;
`ifdef SEG_CMD_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else if (rx_valid) begin
      case (state)
        ST_CMD:     cmd_q     <= rx_byte;
        ST_PAYLOAD: payload_q <= rx_byte;
`ifdef SEG_CMD_CKSUM_EN
        ST_CKSUM:   cksum_q   <= rx_byte;
`endif
        default:    ;
      endcase
    end
  end

  // Apply an accepted command to the display; rejected frames leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits <= '0;
      blank  <= '0;
    end else if (in_exec && frame_good) begin
      case (cmd_q)
        CMD_SET_DIGIT: digits[{payload_q[5:4], 2'b00} +: 4] <= payload_q[3:0];
        CMD_CLEAR: begin
          digits <= '0;
          blank  <= '0;
        end
        CMD_SET_BLANK: blank <= payload_q[3:0];
        default: ;
      endcase
    end
  end

  // Load the response in EXEC and hold it until the transmitter takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (in_exec) begin
      tx_valid <= 1'b1;
      tx_data  <= frame_good ? ACK : NAK;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  // One-cycle status pulses for executed, rejected/timed-out and discarded traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      rx_drop   <= 1'b0;
    end else begin
      frame_ok  <= in_exec && frame_good;
      frame_err <= (in_exec && !frame_good) || tmr_expire;
      rx_drop   <= rx_valid && (in_exec || (state == ST_RESP));
    end
  end

endmodule
